// File: rtl/imc_pkg.sv
// Shared types and sizes for the bit-serial IMC datapath.
package imc_pkg;
   localparam int N_LANES = 16;
   localparam int N_BANKS = 4;
   localparam int W_BITS  = 4;
   localparam int SUM_W   = 8;

   typedef logic [SUM_W-1:0] bank_sum_t;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } acc_state_t;
endpackage

// File: rtl/bank_adder_tree.sv
// Combinational 16-input unsigned adder tree reducing one bank of 4-bit partial
// products to an 8-bit sum (maximum 16 * 15 = 240).
module bank_adder_tree
   import imc_pkg::*;
(
   input  logic [W_BITS-1:0] prod_i [N_LANES],
   output bank_sum_t         sum_o
);

   logic [4:0] lvl1 [8];
   logic [5:0] lvl2 [4];
   logic [6:0] lvl3 [2];

   // Each level is one bit wider than the previous, so no level can overflow.
   for (genvar i = 0; i < 8; i++) begin : g_lvl1
      assign lvl1[i] = {1'b0, prod_i[2*i]} + {1'b0, prod_i[2*i+1]};
   end
   for (genvar i = 0; i < 4; i++) begin : g_lvl2
      assign lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
   end
   for (genvar i = 0; i < 2; i++) begin : g_lvl3
      assign lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
   end

   assign sum_o = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};

endmodule

// File: rtl/bitserial_accumulator.sv
// Bit-serial shift-accumulator: reduces each bank per plane and accumulates MSB-first
// across ACT_BITS planes. Define SIGNED_ACT_EN for two's-complement activations.
//
// state | meaning
// IDLE  | waiting for the MSB plane (in_first=1) of a frame
// ACC   | accumulating planes 2..ACT_BITS of the current frame
module bitserial_accumulator
   import imc_pkg::*;
#(
   parameter int ACT_BITS = 8,
   parameter int ACC_W    = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               in_first,
   output logic               in_ready,
   input  logic [W_BITS-1:0]  mul_result [63:0],
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   acc_out [3:0]
);

   localparam int CNT_W = $clog2(ACT_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACT_BITS - 1);

   acc_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ACC_W-1:0]  acc_q [N_BANKS];
   logic [ACC_W-1:0]  acc_d [N_BANKS];
   logic [ACC_W-1:0]  acc_out_q [N_BANKS];
   logic [ACC_W-1:0]  acc_out_d [N_BANKS];
   logic              out_valid_q, out_valid_d;

   logic [W_BITS-1:0] bank_prod [N_BANKS][N_LANES];
   bank_sum_t         bank_sum  [N_BANKS];
   logic [ACC_W-1:0]  acc_load  [N_BANKS];
   logic [ACC_W-1:0]  acc_shift [N_BANKS];

   logic              final_pending;
   logic              accept;
   logic              capture;

   for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      for (genvar l = 0; l < N_LANES; l++) begin : g_lane
         assign bank_prod[b][l] = mul_result[N_LANES*b + l];
      end

      bank_adder_tree u_tree (
         .prod_i (bank_prod[b]),
         .sum_o  (bank_sum[b])
      );

`ifdef SIGNED_ACT_EN
      // The MSB plane of a two's-complement activation carries weight -2^(ACT_BITS-1).
      assign acc_load[b]  = ACC_W'(0) - ACC_W'(bank_sum[b]);
`else
      assign acc_load[b]  = ACC_W'(bank_sum[b]);
`endif
      assign acc_shift[b] = (acc_q[b] << 1) + ACC_W'(bank_sum[b]);
   end

   // With a single plane per frame every first plane is also the final one.
   assign final_pending = (ACT_BITS == 1) ? 1'b1 : ((state_q == ACC) && (cnt_q == LAST_CNT));
   assign in_ready      = !(out_valid_q && !out_ready && final_pending);
   assign accept        = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      acc_out_d   = acc_out_q;
      out_valid_d = out_valid_q;
      capture     = 1'b0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (in_first) begin
            acc_d = acc_load;
            if (ACT_BITS == 1) begin
               capture = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               state_d = ACC;
               cnt_d   = CNT_W'(1);
            end
         end else if (state_q == ACC) begin
            acc_d = acc_shift;
            if (cnt_q == LAST_CNT) begin
               capture = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      if (capture) begin
         acc_out_d   = acc_d;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         for (int b = 0; b < N_BANKS; b++) begin
            acc_q[b]     <= '0;
            acc_out_q[b] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         for (int b = 0; b < N_BANKS; b++) begin
            acc_q[b]     <= acc_d[b];
            acc_out_q[b] <= acc_out_d[b];
         end
      end
   end

   assign out_valid = out_valid_q;
   for (genvar b = 0; b < N_BANKS; b++) begin : g_out
      assign acc_out[b] = acc_out_q[b];
   end

endmodule
